// File: rtl/wisc_mem_pkg.sv
// wisc_mem_pkg
// Shared types and constants for the unified WISC memory arbiter.
//   state_e : arbiter FSM states (IDLE -> BUSY -> DONE -> IDLE)
//   src_e   : which requester owns the access in flight
//   OP_*    : ISA opcodes relevant to memory traffic and fetch squashing
package wisc_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_e;

endpackage

// File: rtl/wisc_lat_timer.sv
// wisc_lat_timer
// Loadable down-counter that tracks the fixed memory latency of one access.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load_i     : load the counter with MEM_LAT (grant edge)
//   dec_i      : decrement by one (stops at zero)
//   done_o     : counter currently equals 1, i.e. the next edge captures data
module wisc_lat_timer #(
  parameter int MEM_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load has priority so a grant in the same cycle as a stale decrement wins.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(MEM_LAT);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/wisc_mem_arbiter.sv
// wisc_mem_arbiter
// Shares the single-port unified WISC memory between instruction fetch and
// the MEM stage (LW/SW). Data has priority, but after MAX_D_STREAK back-to-back
// data grants with fetch waiting, fetch gets the next slot. A taken branch may
// squash an in-flight fetch; the memory access itself still completes.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   if_req_i/addr_i   : fetch request and address (held until valid or flush)
//   if_flush_i        : squash in-flight fetch
//   if_rdata_o/valid_o: fetched instruction and one-cycle valid pulse
//   d_req_i/we_i/addr_i/wdata_i : data request (we=1 store, we=0 load)
//   d_rdata_o/valid_o : load data and one-cycle completion pulse
//   mem_en_o/we_o/addr_o/wdata_o, mem_rdata_i : memory macro interface
//   busy_o            : an access is in progress (state != IDLE)
module wisc_mem_arbiter
  import wisc_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MEM_LAT      = 4,
  parameter int MAX_D_STREAK = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_valid_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  state_e              state_q, state_d;
  src_e                src_q;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                squash_q;
  logic                mem_en_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;
  logic                if_valid_q, d_valid_q;

  logic grant_d, grant_i, grant;
  logic lat_done;
  logic capture;
  logic flush_now;
  logic squash_now;

  wisc_lat_timer #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (grant),
    .dec_i  (state_q == BUSY),
    .done_o (lat_done)
  );

  // Grants are only issued from IDLE; DONE is a deliberate dead cycle so
  // registered requesters see their valid and can drop req before re-arbitration.
  always_comb begin
    state_d = state_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req_i && (!if_req_i || (streak_q < STREAK_MAX))) begin
          grant_d = 1'b1;
          state_d = BUSY;
        end else if (if_req_i) begin
          grant_i = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (lat_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign grant = grant_d | grant_i;

  // The streak only counts data grants that actually made fetch wait.
  always_comb begin
    streak_d = streak_q;
    if (grant_d) begin
      if (if_req_i) begin
        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);
      end else begin
        streak_d = '0;
      end
    end else if (grant_i) begin
      streak_d = '0;
    end
  end

  // A flush arriving on the capture edge itself also suppresses the fetch data.
  assign capture    = (state_q == BUSY) && lat_done;
  assign flush_now  = (state_q == BUSY) && (src_q == SRC_I) && if_flush_i;
  assign squash_now = squash_q || flush_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      streak_q <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      if (flush_now) begin
        squash_q <= 1'b1;
      end else if (state_q == DONE) begin
        squash_q <= 1'b0;
      end
    end
  end

  // Request fields are latched at grant and held until the next grant, so the
  // memory sees stable address/data for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q       <= SRC_I;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      mem_en_q <= grant;
      if (grant) begin
        src_q       <= grant_d ? SRC_D : SRC_I;
        mem_we_q    <= grant_d && d_we_i;
        mem_addr_q  <= grant_d ? d_addr_i : if_addr_i;
        mem_wdata_q <= grant_d ? d_wdata_i : '0;
      end
      if (capture && (src_q == SRC_D) && !mem_we_q) begin
        d_rdata_q <= mem_rdata_i;
      end
      if (capture && (src_q == SRC_I) && !squash_now) begin
        if_rdata_q <= mem_rdata_i;
      end
      d_valid_q  <= capture && (src_q == SRC_D);
      if_valid_q <= capture && (src_q == SRC_I) && !squash_now;
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_valid_o  = if_valid_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_valid_o   = d_valid_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_wisc_mem_arbiter.sv
// tb_wisc_mem_arbiter
// Directed bench for wisc_mem_arbiter with a behavioural single-port memory
// that reads combinationally from the held address and writes on mem_en&mem_we.
module tb_wisc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req, if_flush, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, d_valid, mem_en, mem_we, busy;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  int memEnCount   = 0;
  int ifValidCount = 0;
  int dValidCount  = 0;

  logic [15:0] memArr [0:65535];
  logic        memLoaded = 1'b0;

  always #5 clk = ~clk;

  wisc_mem_arbiter #(
    .ADDR_W       (16),
    .DATA_W       (16),
    .MEM_LAT      (4),
    .MAX_D_STREAK (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_flush_i  (if_flush),
    .if_rdata_o  (if_rdata),
    .if_valid_o  (if_valid),
    .d_req_i     (d_req),
    .d_we_i      (d_we),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_rdata_o   (d_rdata),
    .d_valid_o   (d_valid),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy)
  );

  // Memory model: preload on the first edge, then accept writes.
  assign mem_rdata = memArr[mem_addr];

  always @(posedge clk) begin
    if (!memLoaded) begin
      memArr[16'h0000] <= 16'h0000;
      memArr[16'h0010] <= 16'hA123;
      memArr[16'h0040] <= 16'h4444;
      memArr[16'h0044] <= 16'h4545;
      memArr[16'h0100] <= 16'h1111;
      memArr[16'h0200] <= 16'h5555;
      memArr[16'h0300] <= 16'h3333;
      memLoaded        <= 1'b1;
    end else if (mem_en && mem_we) begin
      memArr[mem_addr] <= mem_wdata;
    end
  end

  // Activity counters used to prove that something did NOT happen.
  always @(negedge clk) begin
    if (mem_en)   memEnCount++;
    if (if_valid) ifValidCount++;
    if (d_valid)  dValidCount++;
  end

  task automatic applyStimulus(input logic ifReq, input logic [15:0] ifAddr,
                               input logic dReq, input logic dWe,
                               input logic [15:0] dAddr, input logic [15:0] dWdata);
    if_req  = ifReq;
    if_addr = ifAddr;
    d_req   = dReq;
    d_we    = dWe;
    d_addr  = dAddr;
    d_wdata = dWdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Returns how many negedges elapsed until the selected valid is seen, or -1.
  task automatic waitValid(input bit dataSide, output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (dataSide ? d_valid : if_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  int          lat;
  int          snapA, snapB;
  int          g;
  logic [31:0] grantSeq [0:5];
  logic [31:0] expSeq   [0:5];

  initial begin
    if_flush = 1'b0;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

    // ---------------- reset ----------------
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_busy_in_reset", 32'(busy), 32'd0);
    checkOutput("rst_mem_en_in_reset", 32'(mem_en), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
    checkOutput("rst_d_valid", 32'(d_valid), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("rst_if_rdata", 32'(if_rdata), 32'd0);
    checkOutput("rst_d_rdata", 32'(d_rdata), 32'd0);
    checkOutput("rst_mem_en_never", 32'(memEnCount), 32'd0);

    // ---------------- fetch ----------------
    snapA = memEnCount;
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("fetch_mem_en", 32'(mem_en), 32'd1);
    checkOutput("fetch_mem_addr", 32'(mem_addr), 32'h0010);
    checkOutput("fetch_mem_we", 32'(mem_we), 32'd0);
    checkOutput("fetch_busy", 32'(busy), 32'd1);
    waitValid(1'b0, lat);
    checkOutput("fetch_latency", 32'(lat), 32'd4);
    checkOutput("fetch_if_rdata", 32'(if_rdata), 32'hA123);
    checkOutput("fetch_done_busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("fetch_valid_pulse", 32'(if_valid), 32'd0);
    checkOutput("fetch_done_no_grant", 32'(mem_en), 32'd0);
    checkOutput("fetch_idle_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    #1;
    checkOutput("fetch_mem_en_once", 32'(memEnCount - snapA), 32'd1);

    // ---------------- store then load ----------------
    snapB = ifValidCount;
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h0200, 16'hBEEF);
    @(negedge clk);
    checkOutput("sw_mem_en", 32'(mem_en), 32'd1);
    checkOutput("sw_mem_we", 32'(mem_we), 32'd1);
    checkOutput("sw_mem_addr", 32'(mem_addr), 32'h0200);
    checkOutput("sw_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    waitValid(1'b1, lat);
    checkOutput("sw_latency", 32'(lat), 32'd4);
    checkOutput("sw_d_rdata_unchanged", 32'(d_rdata), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);

    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0000);
    @(negedge clk);
    checkOutput("lw_mem_we", 32'(mem_we), 32'd0);
    checkOutput("lw_mem_addr", 32'(mem_addr), 32'h0200);
    waitValid(1'b1, lat);
    checkOutput("lw_latency", 32'(lat), 32'd4);
    checkOutput("lw_d_rdata", 32'(d_rdata), 32'hBEEF);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    #1;
    checkOutput("data_no_if_valid", 32'(ifValidCount - snapB), 32'd0);

    // ---------------- contention ----------------
    expSeq[0] = 32'd1; expSeq[1] = 32'd1; expSeq[2] = 32'd0;
    expSeq[3] = 32'd1; expSeq[4] = 32'd1; expSeq[5] = 32'd0;
    for (int i = 0; i < 6; i++) grantSeq[i] = 32'hFFFF_FFFF;
    g = 0;
    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0300, 16'h0000);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (mem_en) begin
        grantSeq[g] = (mem_addr == 16'h0300) ? 32'd1 : 32'd0;
        g++;
        if (g == 6) begin
          applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0, 16'h0300, 16'h0000);
          break;
        end
      end
    end
    checkOutput("cont_grant_count", 32'(g), 32'd6);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("cont_grant%0d_is_d", i), grantSeq[i], expSeq[i]);
    end
    waitValid(1'b0, lat);
    checkOutput("cont_last_fetch_latency", 32'(lat), 32'd4);
    checkOutput("cont_if_rdata", 32'(if_rdata), 32'h1111);
    checkOutput("cont_d_rdata", 32'(d_rdata), 32'h3333);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);

    // ---------------- flush ----------------
    snapB = ifValidCount;
    applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("flush_mem_addr", 32'(mem_addr), 32'h0040);
    @(negedge clk);
    if_flush = 1'b1;
    applyStimulus(1'b1, 16'h0044, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    if_flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("flush_done_busy", 32'(busy), 32'd1);
    checkOutput("flush_no_valid_done", 32'(if_valid), 32'd0);
    @(negedge clk);
    checkOutput("flush_idle_busy", 32'(busy), 32'd0);
    checkOutput("flush_if_rdata_kept", 32'(if_rdata), 32'h1111);
    #1;
    checkOutput("flush_no_if_valid", 32'(ifValidCount - snapB), 32'd0);
    @(negedge clk);
    checkOutput("refetch_mem_en", 32'(mem_en), 32'd1);
    checkOutput("refetch_mem_addr", 32'(mem_addr), 32'h0044);
    waitValid(1'b0, lat);
    checkOutput("refetch_latency", 32'(lat), 32'd4);
    checkOutput("refetch_if_rdata", 32'(if_rdata), 32'h4545);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);

    // ---------------- async reset mid-access ----------------
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    checkOutput("arst_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("arst_d_rdata", 32'(d_rdata), 32'd0);
    checkOutput("arst_if_rdata", 32'(if_rdata), 32'd0);
    checkOutput("arst_d_valid", 32'(d_valid), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    snapA = memEnCount;
    snapB = dValidCount;
    repeat (8) @(negedge clk);
    #1;
    checkOutput("arst_no_d_valid", 32'(dValidCount - snapB), 32'd0);
    checkOutput("arst_no_mem_en", 32'(memEnCount - snapA), 32'd0);
    checkOutput("arst_idle", 32'(busy), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0000);
    @(negedge clk);
    checkOutput("arst_new_mem_en", 32'(mem_en), 32'd1);
    waitValid(1'b1, lat);
    checkOutput("arst_new_latency", 32'(lat), 32'd4);
    checkOutput("arst_new_d_rdata", 32'(d_rdata), 32'hBEEF);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/wisc_mem_arbiter.md
Name: wisc_mem_arbiter

Overview:
- Shares the single-port unified WISC memory between instruction fetch and the data side (LW opcode 4'h8, SW opcode 4'h9).
- Sits between the fetch stage, the MEM stage and the memory macro. The memory has a fixed access latency.
- Data accesses have priority over fetch. A streak limit ensures fetch is not starved.
- Supports squashing an in-flight fetch on a taken branch (B/BR).

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MEM_LAT, 4, memory latency in cycles, edge of grant to edge of data capture; legal range >=2
MAX_D_STREAK, 2, consecutive data grants allowed while if_req is pending

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held high until if_valid or flush
if_addr  in  ADDR_W  fetch address; stable while if_req is high
if_flush  in  1  squash the in-flight fetch (taken branch)
if_rdata  out  DATA_W  fetched instruction
if_valid  out  1  one-cycle pulse, if_rdata is valid
d_req  in  1  data request; held high until d_valid
d_we  in  1  1=SW, 0=LW
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data
d_valid  out  1  one-cycle pulse, data access complete
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  state is not IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, lat_cnt=0, d_streak=0, squash=0. All outputs 0. Any memory response in flight is discarded.
- States:
  - IDLE -> BUSY on a grant.
  - BUSY -> DONE when lat_cnt==1 at a clock edge.
  - DONE -> IDLE unconditionally.
- Grant rule, evaluated only in IDLE:
  - d_req and (!if_req or d_streak<MAX_D_STREAK) -> grant D.
  - Otherwise if_req -> grant I.
  - Otherwise stay in IDLE.
- d_streak:
  - Increments on a D grant while if_req=1, saturating at MAX_D_STREAK.
  - Clears on an I grant, or on a D grant with if_req=0.
- On the grant edge:
  - Register mem_addr, mem_we (d_we for D, 0 for I) and mem_wdata (d_wdata for D, 0 for I).
  - Record the source. Load lat_cnt=MEM_LAT.
  - mem_en=1 for exactly one cycle, the cycle after the grant edge.
- lat_cnt decrements at each edge in BUSY.
- At the edge where lat_cnt==1:
  - Capture mem_rdata into if_rdata or d_rdata according to the source.
  - Pulse the matching valid during the following (DONE) cycle.
  - The memory must drive mem_rdata in the cycle before that edge.
  - Latency: grant edge to valid = MEM_LAT cycles.
- DONE issues no grant. This lets registered requesters drop req. Sustained throughput is one access per MEM_LAT+2 cycles.
- mem_addr, mem_we and mem_wdata hold their values until the next grant. d_rdata and if_rdata hold until the next capture for the same source.
- SW: mem_rdata is ignored and d_rdata is unchanged. d_valid still pulses.
- if_flush:
  - In BUSY with source I, sets squash. The access still runs to completion (the memory cannot abort).
  - If squash is set, the data is not captured and no if_valid is raised; squash clears in DONE.
  - Flush in IDLE, DONE or BUSY-D has no effect.
  - Flush in the same cycle as an IDLE grant does not cancel that grant. The requester re-flushes in the next cycle.
- if_req and d_req both low in IDLE -> no activity. mem_en never asserts outside the grant+1 cycle.
- mem_we is never 1 for a fetch.

Decomposition:
- Package wisc_mem_pkg:
  - State enum {IDLE, BUSY, DONE}.
  - Source enum {SRC_I, SRC_D}.
  - Opcode constants OP_LW=4'h8, OP_SW=4'h9, OP_B=4'hC, OP_BR=4'hD, OP_HLT=4'hF.
  - ADDR_W/DATA_W defaults.
- One sub-module, wisc_lat_timer: loadable down-counter of width clog2(MEM_LAT+1) with load, done(lat_cnt==1) and async reset.
- FSM, streak logic and datapath registers stay in the top level.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release with no requests -> all outputs 0, busy=0, mem_en never asserts.
- Fetch:
  - Stimulus: if_req=1, if_addr=0x0010; memory returns 0xA123.
  - mem_en high for 1 cycle with mem_addr=0x0010, mem_we=0.
  - if_valid pulses 4 cycles after the grant edge with if_rdata=0xA123, followed by one non-granting DONE cycle.
- Store then load:
  - SW d_addr=0x0200, d_wdata=0xBEEF -> mem_we=1, mem_wdata=0xBEEF, d_valid pulses, d_rdata unchanged.
  - LW 0x0200 with the memory returning 0xBEEF -> d_rdata=0xBEEF.
  - if_valid is never raised.
- Contention: if_req and d_req both held high, each requester re-arming right after its valid -> grant sequence D,D,I,D,D,I (MAX_D_STREAK=2).
- Flush:
  - if_flush=1 in the second BUSY cycle of a fetch to 0x0040 -> no if_valid, if_rdata keeps its old value, busy drops after DONE.
  - A new fetch to 0x0044 is granted at the next IDLE edge.
- Async reset mid-access: rst_n low during BUSY of an LW -> outputs clear with no clock edge. After release there is no d_valid and no mem_en until a new d_req.
